primo_seek: RTL and testbench
=============================

PRIMO_SEEK -- requirements
Module: primo_seek

Interface
REQ-001 SHALL have parameter WIDTH_LOG, default 4, meaning data width W = 2**WIDTH_LOG bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning the prime table holds 2**ADDR_WIDTH - 1 entries.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 go  input  1  request the next prime after res.
REQ-006 load  input  1  request the smallest prime >= seed.
REQ-007 seed  input  W  search start value, sampled only when load is accepted.
REQ-008 ready  output  1  idle; res valid.
REQ-009 error  output  1  sticky overflow/fault flag.
REQ-010 res  output  W  current prime.
REQ-011 cycles  output  W  search-duration statistic (see Configuration).

Function
REQ-012 SHALL accept a request only on a cycle with ready=1, error=0 and go or load high; when both are high, load SHALL win.
REQ-013 ready SHALL fall on the edge after acceptance and rise on the same edge res takes the new prime; requests while ready=0 SHALL be ignored.
REQ-014 States SHALL be IDLE, ERROR, CANDIDATE, TABLE_DIV, TABLE_WAIT, ODD_DIV and ODD_WAIT.
- IDLE -> CANDIDATE on an accepted request.
- Any state -> ERROR on fault.
- Search states -> IDLE when a prime is found.
REQ-015 go SHALL set the candidate to res+1, then step through odd values; 2 SHALL follow 1, and 3 SHALL follow 2.
REQ-016 load SHALL set the candidate to max(seed,2).
- Even candidates > 2 SHALL be skipped to the next odd value.
- A prime seed SHALL be returned unchanged.
REQ-017 A candidate SHALL be prime iff no trial divisor d with d*d <= candidate divides it; d*d SHALL be computed at 2W bits, so squares never overflow.
REQ-018 Trial division SHALL use, in order:
- 2;
- then the odd primes from the table;
- then, if the table is exhausted and d*d <= candidate, the odd values starting at last table entry + 2.
REQ-019 Remainders SHALL come from the team's divrem block; a divrem error SHALL move to ERROR.
REQ-020 A found odd prime SHALL be appended to the table only when the contig flag is set and the table is not full; a full table SHALL be neither written nor wrapped.
REQ-021 contig SHALL be set by rst and cleared by an accepted load, so the table always holds all odd primes from 3 to its last entry.
REQ-022 When a candidate would exceed 2**W - 1, the block SHALL enter ERROR; load of a seed above the largest W-bit prime SHALL also enter ERROR.
REQ-023 In ERROR:
- ready=1 and error=1;
- res SHALL hold the last valid prime;
- go and load SHALL be ignored until rst.

Reset
REQ-024 rst SHALL force IDLE, res=2, ready=1, error=0, cycles=0, table count 0 and contig=1, all on the next edge.
REQ-025 rst asserted mid-search SHALL abort the search with no table write; rst SHALL override every other input.

Configuration
REQ-026 With macro PRIMO_SEEK_STATS_EN defined, cycles SHALL update when ready rises:
- value is the number of clocks from the acceptance edge to the ready-rise edge;
- the count SHALL saturate at 2**W - 1.
REQ-027 Without PRIMO_SEEK_STATS_EN, cycles SHALL be constant 0, with no counter logic.

Verification (WIDTH_LOG=4 unless noted)
REQ-028 rst, then five go pulses -> res=2 after reset, then 3, 5, 7, 11, 13; error=0 throughout.
REQ-029 load with seed=24 -> res=29; then go -> res=31; no table appends occur after the load.
REQ-030 load with seed=0, then load with seed=97 -> res=2, then res=97.
REQ-031 WIDTH_LOG=3, load with seed=251, then go -> res=251, then error=1, ready=1, res=251; a further go is ignored.
REQ-032 ADDR_WIDTH=2 (table of 3 entries), go repeated until res=127 -> every output matches a golden prime list, and the table stays at 3 entries: 3, 5, 7.
REQ-033 go accepted, rst asserted 2 cycles later -> res=2, ready=1 on the next edge; with PRIMO_SEEK_STATS_EN, go from res=23 -> cycles equals the measured clocks to ready.

Source files
------------

// File: rtl/primo_seek.sv
// primo_seek: walks through prime numbers. On go it returns the next prime
// after res; on load it returns the smallest prime >= seed. Each candidate
// is tested by trial division: first by 2, then by the odd primes learned so
// far, then by plain odd numbers once the table runs out.
//
// Optional feature: define PRIMO_SEEK_STATS_EN to enable the search-duration
// counter on 'cycles'. Without the macro, 'cycles' is tied to 0.
//
// Ports
//   clk     clock, rising edge
//   rst     synchronous, active-high reset
//   go      request the next prime after res
//   load    request the smallest prime >= seed (wins over go)
//   seed    search start value, sampled when load is accepted
//   ready   idle (or stopped in error); res is valid
//   error   sticky fault flag (overflow or divider error), cleared by rst
//   res     current prime
//   cycles  clocks taken by the last search, saturating

// Sequential remainder unit: restoring division, one quotient bit per clock.
// A division by zero completes immediately with error set.
module primo_seek_divrem #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic         error,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dvs_q;
    logic [W:0]    rem_sh;
    logic [W-1:0]  diff;
    logic          fits;

    assign rem_sh    = {rem_q, quo_q[W-1]};
    assign fits      = (rem_sh >= {1'b0, dvs_q});
    // Only consumed when fits, so the true difference is below 2**W.
    assign diff      = rem_sh[W-1:0] - dvs_q;
    assign remainder = rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (start && !busy) begin
                if (divisor == '0) begin
                    done  <= 1'b1;
                    error <= 1'b1;
                end else begin
                    busy  <= 1'b1;
                    cnt   <= CW'(W);
                    rem_q <= '0;
                    quo_q <= dividend;
                    dvs_q <= divisor;
                end
            end else if (busy) begin
                rem_q <= fits ? diff : rem_sh[W-1:0];
                quo_q <= {quo_q[W-2:0], fits};
                cnt   <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// State      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for go/load; res valid
// ERROR      | overflow or divider fault; res frozen until rst
// CANDIDATE  | normalise candidate (range check, 2, skip even)
// TABLE_DIV  | next table prime: square test, else start a division
// TABLE_WAIT | waiting for the remainder by a table prime
// ODD_DIV    | next odd divisor past the table: square test or divide
// ODD_WAIT   | waiting for the remainder by an odd divisor
module primo_seek #(
    parameter int WIDTH_LOG  = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic                    load,
    input  logic [2**WIDTH_LOG-1:0] seed,
    output logic                    ready,
    output logic                    error,
    output logic [2**WIDTH_LOG-1:0] res,
    output logic [2**WIDTH_LOG-1:0] cycles
);

    localparam int W         = 2**WIDTH_LOG;
    localparam int TBL_SLOTS = 2**ADDR_WIDTH;
    localparam logic [W:0]            MAXV     = {1'b0, {W{1'b1}}};
    localparam logic [ADDR_WIDTH-1:0] TBL_FULL = '1;

    typedef enum logic [2:0] {
        IDLE,
        ERROR,
        CANDIDATE,
        TABLE_DIV,
        TABLE_WAIT,
        ODD_DIV,
        ODD_WAIT
    } state_t;

    state_t state, state_nxt;

    // Candidate carries one extra bit so stepping past 2**W-1 is visible.
    logic [W:0]            cand;
    logic [W-1:0]          dvs;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] tbl_count;
    logic                  contig;
    logic [W-1:0]          res_q;

    // The top slot is never written: the table holds TBL_SLOTS-1 primes.
    logic [W-1:0] tbl_mem [0:TBL_SLOTS-1];

    logic [W-1:0]   tbl_d;
    logic [W-1:0]   last_entry;
    logic [W-1:0]   odd_start;
    logic [W-1:0]   sq_base;
    logic [2*W-1:0] sq;
    logic           sq_gt;
    logic           cand_over;
    logic           cand_is_two;
    logic           tbl_exhausted;
    logic           tbl_full;
    logic           accept;
    logic           found;
    logic           reject;
    logic           advance;
    logic           tbl_we;

    logic           div_start;
    logic [W-1:0]   div_divisor;
    logic           div_done;
    logic           div_err;
    logic [W-1:0]   div_rem;

    assign ready  = (state == IDLE) || (state == ERROR);
    assign error  = (state == ERROR);
    assign res    = res_q;
    assign accept = (state == IDLE) && (go || load);

    assign tbl_d         = tbl_mem[idx];
    assign last_entry    = tbl_mem[tbl_count - ADDR_WIDTH'(1)];
    assign odd_start     = (tbl_count == '0) ? W'(3) : last_entry + W'(2);
    assign tbl_exhausted = (idx == tbl_count);
    assign tbl_full      = (tbl_count == TBL_FULL);

    assign cand_over   = (cand > MAXV);
    assign cand_is_two = (cand == (W+1)'(2));

    // Squares at double width never overflow.
    assign sq_base     = (state == TABLE_DIV) ? tbl_d : dvs;
    assign sq          = {{W{1'b0}}, sq_base} * {{W{1'b0}}, sq_base};
    assign sq_gt       = (sq > {{(W-1){1'b0}}, cand});
    assign div_divisor = sq_base;

    // Only odd primes beyond the last entry may extend the table, and only
    // while it is known to hold every odd prime from 3 upward.
    assign tbl_we = found && cand[0] && contig && !tbl_full &&
                    ((tbl_count == '0) || (cand[W-1:0] > last_entry));

    primo_seek_divrem #(.W(W)) u_divrem (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (cand[W-1:0]),
        .divisor   (div_divisor),
        .done      (div_done),
        .error     (div_err),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        found     = 1'b0;
        reject    = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = CANDIDATE;
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            CANDIDATE: begin
                if (cand_over) begin
                    state_nxt = ERROR;
                end else if (cand_is_two) begin
                    found     = 1'b1;
                    state_nxt = IDLE;
                end else if (!cand[0]) begin
                    state_nxt = CANDIDATE;
                end else begin
                    state_nxt = TABLE_DIV;
                end
            end
            TABLE_DIV: begin
                if (tbl_exhausted) begin
                    state_nxt = ODD_DIV;
                end else if (sq_gt) begin
                    found     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    div_start = 1'b1;
                    state_nxt = TABLE_WAIT;
                end
            end
            TABLE_WAIT: begin
                if (div_done) begin
                    if (div_err) begin
                        state_nxt = ERROR;
                    end else if (div_rem == '0) begin
                        reject    = 1'b1;
                        state_nxt = CANDIDATE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = TABLE_DIV;
                    end
                end
            end
            ODD_DIV: begin
                if (sq_gt) begin
                    found     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    div_start = 1'b1;
                    state_nxt = ODD_WAIT;
                end
            end
            ODD_WAIT: begin
                if (div_done) begin
                    if (div_err) begin
                        state_nxt = ERROR;
                    end else if (div_rem == '0) begin
                        reject    = 1'b1;
                        state_nxt = CANDIDATE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = ODD_DIV;
                    end
                end
            end
            default: state_nxt = ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand      <= '0;
            dvs       <= '0;
            idx       <= '0;
            tbl_count <= '0;
            contig    <= 1'b1;
            res_q     <= W'(2);
        end else begin
            if (accept) begin
                if (load) begin
                    cand   <= (seed < W'(2)) ? (W+1)'(2) : {1'b0, seed};
                    contig <= 1'b0;
                end else begin
                    cand <= {1'b0, res_q} + (W+1)'(1);
                end
            end
            if (state == CANDIDATE) begin
                idx <= '0;
                if (!cand_over && !cand_is_two && !cand[0])
                    cand <= cand + (W+1)'(1);
            end
            if ((state == TABLE_DIV) && tbl_exhausted)
                dvs <= odd_start;
            if (reject)
                cand <= cand + (W+1)'(2);
            if (advance) begin
                if (state == TABLE_WAIT) idx <= idx + ADDR_WIDTH'(1);
                else                     dvs <= dvs + W'(2);
            end
            if (found)
                res_q <= cand[W-1:0];
            if (tbl_we)
                tbl_count <= tbl_count + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && tbl_we)
            tbl_mem[tbl_count] <= cand[W-1:0];
    end

`ifdef PRIMO_SEEK_STATS_EN
    logic [W-1:0] cyc_cnt;
    logic [W-1:0] cycles_q;
    logic [W-1:0] cyc_inc;

    assign cyc_inc = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + W'(1);
    assign cycles  = cycles_q;

    // cyc_cnt counts search clocks; the value latched as ready rises
    // includes that final edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt  <= '0;
            cycles_q <= '0;
        end else if (accept) begin
            cyc_cnt <= '0;
        end else if (!ready) begin
            cyc_cnt <= cyc_inc;
            if ((state_nxt == IDLE) || (state_nxt == ERROR))
                cycles_q <= cyc_inc;
        end
    end
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_primo_seek.sv
module tb_primo_seek;

    localparam int BUDGET = 5000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, go_a, load_a, ready_a, error_a;
    logic [15:0] seed_a, res_a, cycles_a;
    logic        rst_b, go_b, load_b, ready_b, error_b;
    logic [7:0]  seed_b, res_b, cycles_b;

    primo_seek #(.WIDTH_LOG(4), .ADDR_WIDTH(8)) u_a (
        .clk(clk), .rst(rst_a), .go(go_a), .load(load_a), .seed(seed_a),
        .ready(ready_a), .error(error_a), .res(res_a), .cycles(cycles_a)
    );

    primo_seek #(.WIDTH_LOG(3), .ADDR_WIDTH(2)) u_b (
        .clk(clk), .rst(rst_b), .go(go_b), .load(load_b), .seed(seed_b),
        .ready(ready_b), .error(error_b), .res(res_b), .cycles(cycles_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Smallest prime >= start within [2, maxv]; -1 if none.
    function automatic int seek(input int start, input int maxv);
        for (int c = (start < 2) ? 2 : start; c <= maxv; c++)
            if (is_prime(c)) return c;
        return -1;
    endfunction

    function automatic bit rdy(input bit on_b);
        return on_b ? ready_b : ready_a;
    endfunction

    // One request pulse; waits (bounded) for ready. clocks = edges from the
    // acceptance edge to the edge where ready is seen high again.
    task automatic request(input bit on_b, input bit do_go, input bit do_load,
                           input int sd, output int clocks, output bit timed_out,
                           output bit fell);
        @(negedge clk);
        if (on_b) begin go_b = do_go; load_b = do_load; seed_b = sd[7:0]; end
        else      begin go_a = do_go; load_a = do_load; seed_a = sd[15:0]; end
        @(posedge clk); #1;
        go_a = 0; load_a = 0; go_b = 0; load_b = 0;
        fell   = !rdy(on_b);
        clocks = 0;
        do begin
            @(posedge clk); #1;
            clocks++;
        end while (!rdy(on_b) && clocks < BUDGET);
        timed_out = !rdy(on_b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, exp_a, exp_b, cnt_before, r, sd, guard;
        bit  to, fell;
        int  odd_primes[$];

        rst_a = 1; rst_b = 1; go_a = 0; load_a = 0; seed_a = 0;
        go_b = 0; load_b = 0; seed_b = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready_a, 1);
        check("rst_error", error_a, 0);
        check("rst_res", res_a, 2);
        check("rst_cycles", cycles_a, 0);
        check("rst_tbl_count", u_a.tbl_count, 0);
        check("rst_contig", u_a.contig, 1);
        @(negedge clk);
        rst_a = 0; rst_b = 0;

        // Five go pulses from reset: 3, 5, 7, 11, 13.
        exp_a = 2;
        for (int i = 0; i < 5; i++) begin
            request(0, 1, 0, 0, n, to, fell);
            exp_a = seek(exp_a + 1, 65535);
            check("go_seq_fell", fell, 1);
            check("go_seq_timeout", to, 0);
            check("go_seq_res", res_a, exp_a);
            check("go_seq_error", error_a, 0);
        end
        check("go_seq_tbl_count", u_a.tbl_count, 5);
        for (int c = 3; c <= 13; c += 2)
            if (is_prime(c)) odd_primes.push_back(c);
        for (int i = 0; i < odd_primes.size(); i++)
            check("go_seq_tbl_entry", u_a.tbl_mem[i], odd_primes[i]);

        // Up to 23, then time the go from 23.
        for (int i = 0; i < 3; i++) begin
            request(0, 1, 0, 0, n, to, fell);
            exp_a = seek(exp_a + 1, 65535);
        end
        check("to_23_res", res_a, 23);
        request(0, 1, 0, 0, n, to, fell);
        exp_a = seek(exp_a + 1, 65535);
        check("from_23_res", res_a, exp_a);
`ifdef PRIMO_SEEK_STATS_EN
        check("stats_cycles", cycles_a, n);
`else
        check("stats_off_cycles", cycles_a, 0);
`endif

        // Load 24 -> 29, go -> 31, table untouched after the load.
        cnt_before = int'(u_a.tbl_count);
        request(0, 0, 1, 24, n, to, fell);
        check("load24_res", res_a, 29);
        request(0, 1, 0, 0, n, to, fell);
        check("load24_go_res", res_a, 31);
        check("load24_no_append", u_a.tbl_count, cnt_before);
        check("load24_contig", u_a.contig, 0);

        request(0, 0, 1, 0, n, to, fell);
        check("load0_res", res_a, 2);
        request(0, 0, 1, 97, n, to, fell);
        check("load97_res", res_a, 97);

        // go and load together: load wins.
        request(0, 1, 1, 50, n, to, fell);
        check("both_load_wins", res_a, seek(50, 65535));

        // Requests while busy are ignored.
        @(negedge clk); load_a = 1; seed_a = 16'd1000;
        @(posedge clk); #1;
        check("busy_ready_fell", ready_a, 0);
        check("busy_res_held", res_a, 53);
        go_a = 1; seed_a = 16'd5;
        guard = 0;
        while (!ready_a && guard < BUDGET) begin
            @(posedge clk); #1;
            guard++;
        end
        go_a = 0; load_a = 0;
        check("busy_timeout", ready_a, 1);
        check("busy_res", res_a, seek(1000, 65535));
        repeat (3) @(posedge clk);
        #1;
        check("busy_stays_idle", ready_a, 1);
        check("busy_res_stable", res_a, seek(1000, 65535));
        exp_a = seek(1000, 65535);

        // Randomised go/load mix against the reference model.
        for (int i = 0; i < 15; i++) begin
            r = int'($urandom_range(0, 2));
            if (r == 0) begin
                sd = int'($urandom_range(0, 3000));
                request(0, 0, 1, sd, n, to, fell);
                exp_a = seek(sd, 65535);
            end else begin
                request(0, 1, 0, 0, n, to, fell);
                exp_a = seek(exp_a + 1, 65535);
            end
            check("rand_timeout", to, 0);
            check("rand_res", res_a, exp_a);
            check("rand_error", error_a, 0);
        end

        // rst two cycles after an accepted go aborts the search.
        @(negedge clk); go_a = 1;
        @(posedge clk); #1; go_a = 0;
        check("abort_busy", ready_a, 0);
        @(negedge clk);
        rst_a = 1;
        @(posedge clk); #1;
        check("abort_res", res_a, 2);
        check("abort_ready", ready_a, 1);
        check("abort_error", error_a, 0);
        check("abort_tbl_count", u_a.tbl_count, 0);
        @(negedge clk); rst_a = 0;

        // Small table, 8-bit data: walk to 127.
        exp_b = 2;
        guard = 0;
        while (exp_b < 127 && guard < 40) begin
            request(1, 1, 0, 0, n, to, fell);
            exp_b = seek(exp_b + 1, 255);
            check("b_walk_res", res_b, exp_b);
            check("b_walk_error", error_b, 0);
            guard++;
        end
        check("b_walk_reached", res_b, 127);
        check("b_tbl_count", u_b.tbl_count, 3);
        check("b_tbl_0", u_b.tbl_mem[0], 3);
        check("b_tbl_1", u_b.tbl_mem[1], 5);
        check("b_tbl_2", u_b.tbl_mem[2], 7);

        // 251 is the largest 8-bit prime; the next go overflows.
        request(1, 0, 1, 251, n, to, fell);
        check("b_load251_res", res_b, 251);
        check("b_load251_error", error_b, 0);
        request(1, 1, 0, 0, n, to, fell);
        check("b_ovf_timeout", to, 0);
        check("b_ovf_error", error_b, 1);
        check("b_ovf_ready", ready_b, 1);
        check("b_ovf_res", res_b, 251);
        request(1, 1, 0, 0, n, to, fell);
        check("b_err_go_ignored", fell, 0);
        check("b_err_go_res", res_b, 251);
        request(1, 0, 1, 5, n, to, fell);
        check("b_err_load_ignored", fell, 0);
        check("b_err_load_res", res_b, 251);
        check("b_err_sticky", error_b, 1);

        // Seed above the largest prime also faults.
        @(negedge clk); rst_b = 1;
        @(posedge clk); #1;
        check("b_rst_clears_error", error_b, 0);
        @(negedge clk); rst_b = 0;
        request(1, 0, 1, 252, n, to, fell);
        check("b_load252_error", error_b, 1);
        check("b_load252_res", res_b, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
